voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
Parametrised polyphonic voice allocator. It turns note-on/note-off events into per-voice frequency and volume words for the oscillator bank. It generalises the keyboard front end with:
- configurable voice count and widths
- a handshake on the event input
- retrigger of a note that is already sounding
- oldest-voice stealing or drop-on-full
- exact release by note number
- an all-notes-off command

Key-code decoding stays upstream; this block receives note numbers.

Parameters:
- VOICES, 8, number of voices (2..16).
- NOTE_BITS, 5, width of note number; valid notes 0..2^NOTE_BITS-1.
- FREQ_W, 32, width of frequency outputs (Q.20 fixed point, Hz).
- VOL_W, 32, width of volume outputs.
- FULL_VOL, 1<<20, volume written on note-on.
- BASE_FREQ, 55<<20, frequency of note 0.
- STEAL, 1, 1 = steal oldest voice when full; 0 = drop event and flag overflow.
- AGE_W, 8, width of per-voice age counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ev_valid  in  1  event present
- ev_ready  out  1  block can accept event
- ev_on  in  1  1 = note-on, 0 = note-off
- ev_note  in  NOTE_BITS  note number
- all_off  in  1  single-cycle pulse: silence all voices
- frequencies  out  VOICES x FREQ_W  per-voice frequency
- voice_volumes  out  VOICES x VOL_W  per-voice volume
- voice_active  out  VOICES  per-voice sounding flag
- overflow  out  1  one-cycle pulse: note-on dropped (STEAL=0)

Behaviour:
- Reset (async assert, sync release): all frequencies, voice_volumes, voice_active, ages, stored notes = 0; overflow = 0; FSM = IDLE; ev_ready = 1.
- Note table (constant ROM), note n:
  - semitone s = n mod 12, octave o = n / 12.
  - ratios for s = 0..11: 1, 16/15, 9/8, 6/5, 5/4, 4/3, 45/32, 3/2, 8/5, 5/3, 16/9, 15/8.
  - f = (BASE_FREQ * num / den) << o, except s = 6, which uses (BASE_FREQ / 32 * 45) << o.
  - Computed at elaboration in 64-bit, truncated to FREQ_W.
- FSM states:
  - IDLE: ev_ready = 1. A transfer occurs when ev_valid && ev_ready; capture ev_on and ev_note, go to LOOKUP.
  - LOOKUP: ev_ready = 0. Register table frequency, hit mask (active voices whose note == captured note), free mask (~voice_active), oldest index. Go to COMMIT.
  - COMMIT: ev_ready = 0. Apply the update; go to IDLE. Outputs change on the clock edge leaving COMMIT. Event-to-output latency is 3 edges; throughput is 1 event per 3 cycles.
- Note-on selection, first match wins:
  1. Hit mask non-zero: lowest-index hit voice is retriggered (volume = FULL_VOL, age = 0). No duplicate voice is allocated.
  2. Free voice exists: lowest-index free voice is used.
  3. STEAL=1: voice with the largest age; tie goes to the lowest index.
  4. STEAL=0: no voice change; overflow = 1 for exactly the COMMIT cycle.
- On allocate or retrigger of chosen voice v:
  - frequencies[v] = table f; voice_volumes[v] = FULL_VOL; voice_active[v] = 1; note[v] = ev_note; age[v] = 0.
  - Every other active voice: age += 1, saturating at 2^AGE_W-1.
- Note-off: every voice in the hit mask gets voice_volumes = 0 and voice_active = 0. Frequency and note are held. Ages are unchanged. A note-off with no hit is a no-op.
- all_off: sampled in any state. On the next edge, all volumes = 0, voice_active = 0, ages = 0. Any in-flight event is discarded; FSM = IDLE.
  - all_off has priority over a same-cycle COMMIT and over a same-cycle accept.
- Reset asserted mid-operation: immediate return to reset values; the in-flight event is lost.
- ev_note beyond the table range is impossible by width; all 2^NOTE_BITS entries exist.

Test Plan:
- Reset, then note-on 0 -> 3 edges later voice 0: freq 57671680, vol 1048576, active 1; ev_ready low for exactly 2 cycles.
- Note-on 7, 6, 12 -> voices 0, 1, 2 get freq 86507520, 81100800, 115343360. Note-off 6 -> only voice 1 volume 0, its freq held 81100800.
- Note-on 4 twice without an intervening off -> only voice 0 active, age 0, voice 1 untouched.
- STEAL=1, VOICES=8: note-on 0..8 -> 9th event lands in voice 0 (oldest) with freq of note 8 = 92274688; voice_active = 8'hFF.
- STEAL=0, 8 voices full, note-on 9 -> overflow high for 1 cycle, all outputs unchanged.
- all_off asserted in the same cycle as the COMMIT of a note-on -> all volumes 0, voice_active 0, FSM IDLE, ev_ready 1 next cycle. Async reset pulse mid-LOOKUP -> all outputs 0 immediately.

Source files
------------

// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic voice allocator for the oscillator bank.
// Accepts note-on/note-off events over a valid/ready handshake and keeps
// per-voice frequency, volume, note and age state. Each event runs through
// IDLE -> LOOKUP -> COMMIT, so one event is taken every 3 cycles.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   ev_valid/ev_ready event handshake
//   ev_on, ev_note    1 = note-on / 0 = note-off, note number
//   all_off           single-cycle pulse: silence every voice, drop in-flight event
//   frequencies       per-voice frequency word (Q.20 Hz)
//   voice_volumes     per-voice volume word
//   voice_active      per-voice sounding flag
//   overflow          high during COMMIT of a dropped note-on (STEAL = 0 only)
module voice_allocator #(
  parameter int              VOICES    = 8,
  parameter int              NOTE_BITS = 5,
  parameter int              FREQ_W    = 32,
  parameter int              VOL_W     = 32,
  parameter longint unsigned FULL_VOL  = 64'd1 << 20,
  parameter longint unsigned BASE_FREQ = 64'd55 << 20,
  parameter int              STEAL     = 1,
  parameter int              AGE_W     = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           ev_valid,
  output logic                           ev_ready,
  input  logic                           ev_on,
  input  logic [NOTE_BITS-1:0]           ev_note,
  input  logic                           all_off,
  output logic [VOICES-1:0][FREQ_W-1:0]  frequencies,
  output logic [VOICES-1:0][VOL_W-1:0]   voice_volumes,
  output logic [VOICES-1:0]              voice_active,
  output logic                           overflow
);

  localparam int IDX_W = $clog2(VOICES);
  localparam int NOTES = 1 << NOTE_BITS;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};
  localparam logic [VOL_W-1:0] FULL    = VOL_W'(FULL_VOL);

  // Just-intonation ratio applied to BASE_FREQ, shifted up by octave.
  // The tritone divides first so 45 * BASE_FREQ cannot lose its top bits.
  function automatic logic [FREQ_W-1:0] note_freq(input int n);
    logic [63:0] f;
    logic [3:0]  s;
    int          o;
    s = 4'(n % 32'sd12);
    o = n / 32'sd12;
    case (s)
      4'd0:    f = BASE_FREQ;
      4'd1:    f = BASE_FREQ * 64'd16 / 64'd15;
      4'd2:    f = BASE_FREQ * 64'd9  / 64'd8;
      4'd3:    f = BASE_FREQ * 64'd6  / 64'd5;
      4'd4:    f = BASE_FREQ * 64'd5  / 64'd4;
      4'd5:    f = BASE_FREQ * 64'd4  / 64'd3;
      4'd6:    f = BASE_FREQ / 64'd32 * 64'd45;
      4'd7:    f = BASE_FREQ * 64'd3  / 64'd2;
      4'd8:    f = BASE_FREQ * 64'd8  / 64'd5;
      4'd9:    f = BASE_FREQ * 64'd5  / 64'd3;
      4'd10:   f = BASE_FREQ * 64'd16 / 64'd9;
      4'd11:   f = BASE_FREQ * 64'd15 / 64'd8;
      default: f = BASE_FREQ;
    endcase
    f = f << o;
    return FREQ_W'(f);
  endfunction

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [IDX_W-1:0] lowest(input logic [VOICES-1:0] m);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (m[i]) idx = IDX_W'(i);
      else      idx = idx;
    end
    return idx;
  endfunction

  logic [FREQ_W-1:0] rom [NOTES];

  for (genvar g = 0; g < NOTES; g++) begin : g_rom
    assign rom[g] = note_freq(g);
  end

  logic [1:0]                       state_r, state_nxt_s;
  logic                             on_r;
  logic [NOTE_BITS-1:0]             note_r;
  logic [FREQ_W-1:0]                freq_r;
  logic [VOICES-1:0]                hit_r, free_r;
  logic [IDX_W-1:0]                 oldest_r;
  logic [VOICES-1:0][NOTE_BITS-1:0] notes_r;
  logic [VOICES-1:0][AGE_W-1:0]     ages_r;

  logic [VOICES-1:0] hit_s;
  logic [IDX_W-1:0]  oldest_s;
  logic [AGE_W-1:0]  best_age_s;
  logic              drop_s;
  logic              take_s;
  logic [IDX_W-1:0]  sel_s;

  // Lookup-stage masks and oldest voice (largest age, lowest index on tie).
  always_comb begin
    hit_s      = '0;
    oldest_s   = '0;
    best_age_s = ages_r[0];
    for (int i = 0; i < VOICES; i++) begin
      if (voice_active[i] && (notes_r[i] == note_r)) hit_s[i] = 1'b1;
      else                                            hit_s[i] = 1'b0;
    end
    for (int i = 1; i < VOICES; i++) begin
      if (ages_r[i] > best_age_s) begin
        best_age_s = ages_r[i];
        oldest_s   = IDX_W'(i);
      end else begin
        best_age_s = best_age_s;
      end
    end
    drop_s = on_r && (hit_s == '0) && (voice_active == {VOICES{1'b1}}) && (STEAL == 0);
  end

  // Commit-stage voice choice: retrigger hit, else free voice, else oldest.
  always_comb begin
    take_s = 1'b0;
    sel_s  = oldest_r;
    if (hit_r != '0) begin
      take_s = 1'b1;
      sel_s  = lowest(hit_r);
    end else if (free_r != '0) begin
      take_s = 1'b1;
      sel_s  = lowest(free_r);
    end else begin
      take_s = (STEAL != 0);
      sel_s  = oldest_r;
    end
  end

  // Next FSM state; all_off returns to IDLE from anywhere.
  always_comb begin
    state_nxt_s = ST_IDLE;
    if (all_off) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:   state_nxt_s = (ev_valid && ev_ready) ? ST_LOOKUP : ST_IDLE;
        ST_LOOKUP: state_nxt_s = ST_COMMIT;
        ST_COMMIT: state_nxt_s = ST_IDLE;
        default:   state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM, event capture, lookup registers and overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      ev_ready <= 1'b1;
      on_r     <= 1'b0;
      note_r   <= '0;
      freq_r   <= '0;
      hit_r    <= '0;
      free_r   <= '0;
      oldest_r <= '0;
      overflow <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      ev_ready <= (state_nxt_s == ST_IDLE);
      if (!all_off && state_r == ST_IDLE && ev_valid) begin
        on_r   <= ev_on;
        note_r <= ev_note;
      end
      if (state_r == ST_LOOKUP) begin
        freq_r   <= rom[note_r];
        hit_r    <= hit_s;
        free_r   <= ~voice_active;
        oldest_r <= oldest_s;
      end
      // Raised on entry to COMMIT so it is high for exactly that cycle.
      overflow <= !all_off && (state_r == ST_LOOKUP) && drop_s;
    end
  end

  // Per-voice state: allocate/retrigger, release, and all-notes-off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frequencies   <= '0;
      voice_volumes <= '0;
      voice_active  <= '0;
      notes_r       <= '0;
      ages_r        <= '0;
    end else if (all_off) begin
      voice_volumes <= '0;
      voice_active  <= '0;
      ages_r        <= '0;
    end else if (state_r == ST_COMMIT && on_r && take_s) begin
      for (int i = 0; i < VOICES; i++) begin
        if (IDX_W'(i) == sel_s) begin
          frequencies[i]   <= freq_r;
          voice_volumes[i] <= FULL;
          voice_active[i]  <= 1'b1;
          notes_r[i]       <= note_r;
          ages_r[i]        <= '0;
        end else if (voice_active[i] && ages_r[i] != AGE_MAX) begin
          ages_r[i] <= ages_r[i] + {{(AGE_W-1){1'b0}}, 1'b1};
        end
      end
    end else if (state_r == ST_COMMIT && !on_r) begin
      for (int i = 0; i < VOICES; i++) begin
        if (hit_r[i]) begin
          voice_volumes[i] <= '0;
          voice_active[i]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;

  logic clk = 1'b0;
  logic reset_n, ev_valid, ev_on, all_off;
  logic [4:0] ev_note;

  logic [7:0][31:0] freq_a, vol_a, freq_b, vol_b;
  logic [7:0]       act_a, act_b;
  logic             ready_a, ready_b, ovf_a, ovf_b;

  always #5 clk = ~clk;

  voice_allocator #(.STEAL(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .ev_valid(ev_valid), .ev_ready(ready_a),
    .ev_on(ev_on), .ev_note(ev_note), .all_off(all_off),
    .frequencies(freq_a), .voice_volumes(vol_a), .voice_active(act_a), .overflow(ovf_a));

  voice_allocator #(.STEAL(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .ev_valid(ev_valid), .ev_ready(ready_b),
    .ev_on(ev_on), .ev_note(ev_note), .all_off(all_off),
    .frequencies(freq_b), .voice_volumes(vol_b), .voice_active(act_b), .overflow(ovf_b));

  localparam logic [31:0] FULL = 32'd1048576;

  typedef struct packed {
    logic [7:0][31:0] fa, va, fb, vb;
    logic [7:0]       aa, ab;
    logic             ob;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Hand-computed table frequencies for notes 0..9.
  logic [31:0] nf [0:9];

  logic [7:0][31:0] ef_a, ev_a, ef_b, ev_b;
  logic [7:0]       ea_a, ea_b;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_on(input bit da, input bit db, input int v, input logic [31:0] f);
    if (da) begin ef_a[v] = f; ev_a[v] = FULL; ea_a[v] = 1'b1; end
    if (db) begin ef_b[v] = f; ev_b[v] = FULL; ea_b[v] = 1'b1; end
  endtask

  task automatic set_off(input int v);
    ev_a[v] = 32'd0; ea_a[v] = 1'b0;
    ev_b[v] = 32'd0; ea_b[v] = 1'b0;
  endtask

  task automatic clr_all();
    ev_a = '0; ea_a = '0; ev_b = '0; ea_b = '0;
  endtask

  task automatic push(input logic ob);
    exp_t e;
    e.fa = ef_a; e.va = ev_a; e.aa = ea_a;
    e.fb = ef_b; e.vb = ev_b; e.ab = ea_b;
    e.ob = ob;
    q.push_back(e);
  endtask

  // Issue one event; optionally pulse all_off during its COMMIT cycle.
  task automatic send(input logic on, input logic [4:0] n, input bit aoff);
    int low;
    @(negedge clk);
    ev_valid = 1'b1; ev_on = on; ev_note = n;
    @(negedge clk);
    ev_valid = 1'b0;
    low = 0;
    while (ready_a == 1'b0 && low < 8) begin
      low++;
      if (aoff && low == 2) all_off = 1'b1;
      @(negedge clk);
    end
    all_off = 1'b0;
    check("ready_low_cycles", 256'(low), 256'(2));
  endtask

  task automatic pulse_off();
    @(negedge clk);
    all_off = 1'b1;
    @(negedge clk);
    all_off = 1'b0;
    clr_all();
  endtask

  // Monitor: each rise of ev_ready marks a finished event; compare against queue.
  initial begin
    logic prev, seen_a, seen_b;
    exp_t e;
    prev = 1'b1; seen_a = 1'b0; seen_b = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev = 1'b1; seen_a = 1'b0; seen_b = 1'b0;
      end else begin
        if (ovf_a) seen_a = 1'b1;
        if (ovf_b) seen_b = 1'b1;
        if (ready_a && !prev) begin
          if (q.size() == 0) begin
            check("unexpected_output", 256'(1), 256'(0));
          end else begin
            e = q.pop_front();
            check("freq_steal", freq_a, e.fa);
            check("vol_steal", vol_a, e.va);
            check("active_steal", 256'(act_a), 256'(e.aa));
            check("freq_drop", freq_b, e.fb);
            check("vol_drop", vol_b, e.vb);
            check("active_drop", 256'(act_b), 256'(e.ab));
            check("overflow_steal", 256'(seen_a), 256'(0));
            check("overflow_drop", 256'(seen_b), 256'(e.ob));
            check("ready_match", 256'(ready_b), 256'(1));
          end
          seen_a = 1'b0; seen_b = 1'b0;
        end
        prev = ready_a;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nf = '{32'd57671680, 32'd61516458, 32'd64880640, 32'd69206016, 32'd72089600,
           32'd76895573, 32'd81100800, 32'd86507520, 32'd92274688, 32'd96119466};
    ef_a = '0; ef_b = '0; clr_all();
    reset_n = 1'b0; ev_valid = 1'b0; ev_on = 1'b0; ev_note = 5'd0; all_off = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready", 256'(ready_a), 256'(1));
    check("reset_freq", freq_a, 256'(0));
    check("reset_vol", vol_a, 256'(0));
    check("reset_active", 256'(act_a), 256'(0));
    check("reset_overflow", 256'(ovf_b), 256'(0));
    #2 reset_n = 1'b1;

    // First note-on lands in voice 0.
    set_on(1, 1, 0, nf[0]); push(1'b0); send(1'b1, 5'd0, 1'b0);

    // Three notes then release of the middle one.
    pulse_off();
    set_on(1, 1, 0, nf[7]);         push(1'b0); send(1'b1, 5'd7, 1'b0);
    set_on(1, 1, 1, nf[6]);         push(1'b0); send(1'b1, 5'd6, 1'b0);
    set_on(1, 1, 2, 32'd115343360); push(1'b0); send(1'b1, 5'd12, 1'b0);
    set_off(1);                     push(1'b0); send(1'b0, 5'd6, 1'b0);
    push(1'b0); send(1'b0, 5'd20, 1'b0);  // note-off with no hit

    // Retrigger: same note twice stays in voice 0.
    pulse_off();
    set_on(1, 1, 0, nf[4]); push(1'b0); send(1'b1, 5'd4, 1'b0);
    push(1'b0); send(1'b1, 5'd4, 1'b0);

    // Fill all 8 voices, then overflow behaviour.
    pulse_off();
    for (int n = 0; n < 8; n++) begin
      set_on(1, 1, n, nf[n]); push(1'b0); send(1'b1, 5'(n), 1'b0);
    end
    set_on(1, 0, 0, nf[8]); push(1'b1); send(1'b1, 5'd8, 1'b0);  // steals voice 0
    set_on(1, 0, 1, nf[9]); push(1'b1); send(1'b1, 5'd9, 1'b0);  // voice 1 now oldest

    // all_off in the same cycle as a note-on COMMIT wins.
    pulse_off();
    push(1'b0); send(1'b1, 5'd3, 1'b1);

    // Asynchronous reset while the event is in LOOKUP.
    @(negedge clk);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 5'd5;
    @(negedge clk);
    ev_valid = 1'b0;
    check("in_lookup_ready", 256'(ready_a), 256'(0));
    #1 reset_n = 1'b0;
    #1;
    check("async_freq", freq_a, 256'(0));
    check("async_vol", vol_a, 256'(0));
    check("async_active", 256'(act_b), 256'(0));
    check("async_ready", 256'(ready_a), 256'(1));
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    ef_a = '0; ef_b = '0; clr_all();
    set_on(1, 1, 0, nf[0]); push(1'b0); send(1'b1, 5'd0, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_drained", 256'(q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
